// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared LSU state, size and exception encodings
// Purpose: constants used by the load/store unit, its load aligner and its bench.
// Ports: none (package).
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_REQ   = 2'd1,
    LSU_RESP  = 2'd2,
    LSU_FAULT = 2'd3
  } lsu_state_e;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  localparam int EXCEPTION_LEN = 4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK               = 4'd0;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_LOAD_MISALIGNED  = 4'd4;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_LOAD_FAULT       = 4'd5;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_STORE_MISALIGNED = 4'd6;
  localparam logic [EXCEPTION_LEN-1:0] EXCEP_STORE_FAULT      = 4'd7;

  // Max cycles spent in REQ without mem_ack before an access fault.
  localparam int TIMEOUT_CYCLES = 16;

  // Size code 3 is treated as a misaligned access: it can never be issued.
  function automatic logic lsu_bad_access(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      LSU_SIZE_B: return 1'b0;
      LSU_SIZE_H: return offset[0];
      LSU_SIZE_W: return offset != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - single-outstanding req/ack data-memory bus
// Purpose: groups the LSU data bus; master = LSU, slave = memory.
// Signals: req/we/addr/wdata/wstrb (master->slave), ack/rdata (slave->master).
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
  modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/load_store_unit_load_align.sv
// rtl/load_store_unit_load_align.sv - load data lane select and extension
// Purpose: module lsu_load_align picks the addressed byte/half of a read word
// and sign- or zero-extends it to 32 bits (combinational).
// Ports: rdata (read word), offset (addr[1:0]), size, is_unsigned -> result.
module lsu_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (size)
      LSU_SIZE_B: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      LSU_SIZE_H: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default:    result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with exception reporting
// Purpose: accepts one load/store from the Executor, runs one bus transaction,
// aligns/extends load data into the RegisterFile write port, stalls the core
// while busy and latches misaligned/fault codes until reset.
// Ports: clk, rst (async, active-high); req_* request from Executor;
// execLockSet_Out stall; rdAddr_Out/rdWrite_Out/rdEnable_Out register write;
// mem (load_store_unit_if.master) data bus; exception_Out fault code.
// Option: LSU_TIMEOUT_EN enables the REQ timeout -> access fault.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [4:0]               req_rd,
  output logic                     execLockSet_Out,
  output logic [4:0]               rdAddr_Out,
  output logic [31:0]              rdWrite_Out,
  output logic                     rdEnable_Out,
  load_store_unit_if.master        mem,
  output logic [EXCEPTION_LEN-1:0] exception_Out
);

  lsu_state_e state_q, state_d;
  logic [EXCEPTION_LEN-1:0] exc_q, exc_d;

  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        we_q, uns_q;
  logic [1:0]  size_q, off_q;
  logic [4:0]  rd_q;

  logic        bad_access, accept, timeout;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;

  assign bad_access = lsu_bad_access(req_size, req_addr[1:0]);
  assign accept     = (state_q == LSU_IDLE) && req_valid && !bad_access;

  // Store data is replicated across lanes so the strobe alone selects bytes.
  always_comb begin
    lane_wstrb = 4'b0000;
    lane_wdata = 32'd0;
    if (req_write) begin
      case (req_size)
        LSU_SIZE_B: begin
          lane_wstrb = 4'b0001 << req_addr[1:0];
          lane_wdata = {4{req_wdata[7:0]}};
        end
        LSU_SIZE_H: begin
          lane_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{req_wdata[15:0]}};
        end
        default: begin
          lane_wstrb = 4'b1111;
          lane_wdata = req_wdata;
        end
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] tmo_q;

  // Only IDLE leads into REQ, so clearing in IDLE clears on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (state_q == LSU_REQ) begin
      tmo_q <= tmo_q + 1'b1;
    end else begin
      tmo_q <= '0;
    end
  end

  assign timeout = (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    case (state_q)
      LSU_IDLE: begin
        if (req_valid) begin
          if (bad_access) begin
            state_d = LSU_FAULT;
            exc_d   = req_write ? EXCEP_STORE_MISALIGNED : EXCEP_LOAD_MISALIGNED;
          end else begin
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        if (mem.ack) begin
          state_d = we_q ? LSU_IDLE : LSU_RESP;
        end else if (timeout) begin
          state_d = LSU_FAULT;
          exc_d   = we_q ? EXCEP_STORE_FAULT : EXCEP_LOAD_FAULT;
        end
      end
      LSU_RESP: state_d = LSU_IDLE;
      default:  state_d = LSU_FAULT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      exc_q   <= EXCEP_OK;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'b0000;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= LSU_SIZE_B;
      off_q   <= 2'd0;
      rd_q    <= 5'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      if (accept) begin
        addr_q  <= {req_addr[31:2], 2'b00};
        wdata_q <= lane_wdata;
        wstrb_q <= lane_wstrb;
        we_q    <= req_write;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        rd_q    <= req_rd;
      end
      if (state_q == LSU_REQ && mem.ack) begin
        rdata_q <= mem.rdata;
      end
    end
  end

  lsu_load_align u_load_align (
    .rdata       (rdata_q),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (rdWrite_Out)
  );

  assign mem.req         = (state_q == LSU_REQ);
  assign mem.we          = we_q;
  assign mem.addr        = addr_q;
  assign mem.wdata       = wdata_q;
  assign mem.wstrb       = wstrb_q;
  assign rdAddr_Out      = rd_q;
  assign rdEnable_Out    = (state_q == LSU_RESP) && (rd_q != 5'd0);
  assign execLockSet_Out = (state_q != LSU_IDLE) || req_valid;
  assign exception_Out   = exc_q;

endmodule
